// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file: widths, the zero-register
// index and the packed register-array type used by the write side and read muxes.
package regfile_pkg;

  localparam int XLEN     = 64;
  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int CW       = 16;
  localparam int ZERO_REG = 31;

  typedef logic [XLEN-1:0] word_t;
  typedef word_t [NREGS-1:0] reg_array_t;

endpackage

// File: rtl/regfile_decoder5_32.sv
// Combinational 5-to-32 one-hot decoder with enable; all-zero when disabled.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [NREGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr6432.sv
// Write side of the 32 x 64-bit integer register file. Register 31 reads as
// zero and silently drops writes; written/wr_count track accepted writes.
module regfile_wr6432
  import regfile_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  output logic [NREGS-1:0][XLEN-1:0]    regs,
  output logic [NREGS-1:0]              wr_onehot,
  output logic [NREGS-1:0]              written,
  output logic [CW-1:0]                 wr_count
);

  localparam logic [NREGS-1:0] ZERO_MASK = NREGS'(1) << ZERO_REG;
  localparam logic [CW-1:0]    CNT_MAX   = '1;

  logic [NREGS-1:0] dec_onehot;
  logic             accepted;
  word_t            slice_q [ZERO_REG];
  logic [ZERO_REG-1:0] written_q;

  decoder5_32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (dec_onehot)
  );

  // The XZR bit is masked here so one vector drives both the slices and the flags.
  assign wr_onehot = dec_onehot & ~ZERO_MASK;
  assign accepted  = |wr_onehot;

  for (genvar g = 0; g < ZERO_REG; g++) begin : g_slice
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        slice_q[g] <= '0;
      end else if (wr_onehot[g]) begin
        slice_q[g] <= wr_data;
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < ZERO_REG; i++) begin
      regs[i] = slice_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_q <= '0;
    end else begin
      written_q <= written_q | wr_onehot[ZERO_REG-1:0];
    end
  end

  assign written = {1'b1, written_q};

  // Saturating: once at all-ones the counter holds rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (accepted && (wr_count != CNT_MAX)) begin
      wr_count <= wr_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wr6432.sv
// Directed bench for regfile_wr6432: drivers push expected values into a
// scoreboard queue, a negedge monitor pops and compares against the DUT.
module tb_regfile_wr6432;
  import regfile_pkg::*;

  localparam int K_REG = 0, K_WRITTEN = 1, K_COUNT = 2, K_ONEHOT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset_n;
  logic                       wr_en;
  logic [4:0]                 wr_addr;
  logic [63:0]                wr_data;
  logic [31:0][63:0]          regs;
  logic [31:0]                wr_onehot;
  logic [31:0]                written;
  logic [15:0]                wr_count;

  regfile_wr6432 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs      (regs),
    .wr_onehot (wr_onehot),
    .written   (written),
    .wr_count  (wr_count)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  int          kind_q[$];
  int          idx_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic expect_val(input int kind, input int idx, input logic [63:0] val,
                            input string name);
    exp_q.push_back(val);
    kind_q.push_back(kind);
    idx_q.push_back(idx);
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [63:0] e, act;
      int k, ix;
      string nm;
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      ix = idx_q.pop_front();
      nm = name_q.pop_front();
      case (k)
        K_REG:     act = regs[ix];
        K_WRITTEN: act = {32'b0, written};
        K_COUNT:   act = {48'b0, wr_count};
        default:   act = {32'b0, wr_onehot};
      endcase
      n_vec++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, ix, $time, act, e);
      end
    end
  end

  // drivers: called at posedge+1, return at the following posedge+1
  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    expect_val(K_ONEHOT, int'(a), (a == 5'd31) ? 64'd0 : (64'd1 << a), "onehot");
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #2;

    // asynchronous reset mid-cycle, checked before any further rising edge
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) expect_val(K_REG, i, 64'd0, "rst_regs");
    expect_val(K_WRITTEN, 0, 64'h8000_0000, "rst_written");
    expect_val(K_COUNT, 0, 64'd0, "rst_count");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // basic writes
    do_write(5'd9, 64'd1309);
    do_write(5'd13, 64'd13);
    for (int i = 0; i < 32; i++)
      expect_val(K_REG, i, (i == 9) ? 64'd1309 : (i == 13) ? 64'd13 : 64'd0, "basic_regs");
    expect_val(K_WRITTEN, 0, 64'h8000_2200, "basic_written");
    expect_val(K_COUNT, 0, 64'd2, "basic_count");

    // XZR write is dropped
    do_write(5'd31, 64'hDEAD_BEEF);
    expect_val(K_REG, 31, 64'd0, "xzr_reg");
    expect_val(K_COUNT, 0, 64'd2, "xzr_count");
    expect_val(K_WRITTEN, 0, 64'h8000_2200, "xzr_written");

    // decode disabled
    wr_en = 1'b0; wr_addr = 5'd4;
    expect_val(K_ONEHOT, 4, 64'd0, "onehot_off");
    @(posedge clk); #1;

    // back-to-back writes to register 5
    do_write(5'd5, 64'h1);
    expect_val(K_REG, 5, 64'h1, "b2b_1");
    do_write(5'd5, 64'h2);
    expect_val(K_REG, 5, 64'h2, "b2b_2");
    do_write(5'd5, 64'h3);
    expect_val(K_REG, 5, 64'h3, "b2b_3");
    expect_val(K_COUNT, 0, 64'd5, "b2b_count");

    // zero data is still an accepted write
    do_write(5'd20, 64'd0);
    expect_val(K_WRITTEN, 0, 64'h8010_2220, "zero_written");
    expect_val(K_COUNT, 0, 64'd6, "zero_count");

    // reset asserted on the same edge as a write to register 7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h777;
    @(posedge clk);
    reset_n = 1'b0;
    #1;
    wr_en = 1'b0;
    expect_val(K_REG, 7, 64'd0, "rstw_reg7");
    expect_val(K_REG, 5, 64'd0, "rstw_reg5");
    expect_val(K_WRITTEN, 0, 64'h8000_0000, "rstw_written");
    expect_val(K_COUNT, 0, 64'd0, "rstw_count");
    @(posedge clk); #1;
    expect_val(K_REG, 7, 64'd0, "rst_hold_reg7");
    reset_n = 1'b1;

    // sweep every address
    for (int i = 0; i < 32; i++) do_write(5'(i), 64'(i) * 64'h0101);
    for (int i = 0; i < 32; i++)
      expect_val(K_REG, i, (i == 31) ? 64'd0 : 64'(i) * 64'h0101, "sweep_regs");
    expect_val(K_WRITTEN, 0, 64'hFFFF_FFFF, "sweep_written");
    expect_val(K_COUNT, 0, 64'd31, "sweep_count");

    // saturation: 31 + 70000 accepted writes exceeds 16'hFFFF
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h5A5A;
    repeat (70000) @(posedge clk);
    #1;
    wr_en = 1'b0;
    expect_val(K_COUNT, 0, 64'hFFFF, "sat_count");
    expect_val(K_REG, 3, 64'h5A5A, "sat_reg3");
    do_write(5'd2, 64'h22);
    expect_val(K_COUNT, 0, 64'hFFFF, "sat_hold");
    expect_val(K_REG, 2, 64'h22, "sat_reg2");

    // final report
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr6432.md
# regfile_wr6432

Write side of the 32 × 64-bit integer register file. Decodes a 5-bit destination address into a 32-bit one-hot write-enable, and holds the 32 architectural registers in flops. The flops drive the packed `[31:0][63:0]` bus that feeds the read-port 32:1 × 64 multiplexers. Register 31 is the hardwired zero register (XZR): it always reads 0 and is never written.

## Interface
- `XLEN`, 64, register width in bits.
- `NREGS`, 32, number of architectural registers; the address width is log2(`NREGS`) = 5.
- `ZERO_REG`, 31, index of the hardwired-zero register.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request for the current cycle.
- `wr_addr`  in  5  destination register index.
- `wr_data`  in  `XLEN`  write data.
- `regs`  out  [`NREGS`-1:0][`XLEN`-1:0]  current contents of all registers; connects directly to the read-mux data input.
- `wr_onehot`  out  `NREGS`  combinational decode of `wr_addr`, gated by `wr_en`.
- `written`  out  `NREGS`  per-register flag, set by the first accepted write since reset.
- `wr_count`  out  16  number of accepted writes since reset; saturates.

## Operation
- Decode: `wr_onehot[i]` = `wr_en` && (`wr_addr` == i) && (i != `ZERO_REG`).
  - At most one bit is high.
  - It is all-zero when `wr_en` = 0 or `wr_addr` = 31.
- Accepted write: any cycle in which `wr_onehot` is non-zero.
  - On the rising edge of `clk`, register[`wr_addr`] takes `wr_data`.
  - All other registers hold their value.
- Register 31:
  - `regs[31]` is the constant 0.
  - A write addressed to 31 is dropped silently: no data change, `written[31]` does not change, `wr_count` does not increment.
- `written[i]`:
  - Sticky; set on the first accepted write to register i and cleared only by reset.
  - `written[31]` is tied to 1, because XZR is always valid.
- `wr_count`:
  - Increments by 1 on each accepted write.
  - Holds at 16'hFFFF once reached; it never wraps.
- Writes with `wr_data` = 0 are ordinary writes: `written` is set and `wr_count` increments.
- No read-during-write bypass: a read that selects the register being written sees the old value in that cycle.

## Timing
- Write latency is 1 cycle. Data presented at edge N is visible on `regs` after edge N.
- `wr_onehot` is combinational from `wr_en` and `wr_addr`, with zero latency.
- Reset, on assertion (`reset_n` = 0), asynchronously and immediately:
  - all `regs` = 0;
  - `written` = 32'h8000_0000;
  - `wr_count` = 0.
- While `reset_n` = 0, rising edges perform no write, even if `wr_en` = 1.
- Reset mid-operation: a write whose edge coincides with, or follows, the assertion of `reset_n` is lost.
- Release of `reset_n` is synchronised externally. The first write can be taken on the first rising edge after release.
- There is no handshake and no backpressure. Every cycle with `wr_en` = 1 and `wr_addr` ≠ 31 is accepted.

## Structure
- Package `regfile_pkg` holds the shared definitions, which the read-mux wrapper also uses:
  - localparams `XLEN` = 64, `NREGS` = 32, `ZERO_REG` = 31;
  - `typedef logic [XLEN-1:0] word_t`;
  - `typedef word_t [NREGS-1:0] reg_array_t`.
- Sub-module `decoder5_32`: combinational 5-to-32 one-hot decoder with an enable input.
- One generate loop instantiates 31 enabled 64-bit register slices for indices 0–30. Index 31 is a constant assignment.
- `written` and `wr_count` are small always_ff blocks in the top module.

## Test plan
- Reset values: assert `reset_n` = 0 mid-cycle → asynchronously, all `regs` = 0, `written` = 32'h8000_0000 and `wr_count` = 0.
- Basic write: write 64'd1309 to register 9 and 64'd13 to register 13 → after the edges, `regs[9]` = 1309, `regs[13]` = 13, every other register = 0, `written` = 32'h8000_2200, `wr_count` = 2.
- XZR protection: `wr_en` = 1, `wr_addr` = 31, `wr_data` = 64'hDEAD_BEEF → `wr_onehot` = 0, `regs[31]` = 0, `wr_count` does not change.
- Back-to-back writes: write register 5 on consecutive cycles with 64'h1, then 64'h2, then 64'h3 → after each edge `regs[5]` follows 1, 2, 3; `wr_count` increases by 3.
- Reset during write: assert `reset_n` = 0 with `wr_en` = 1 to register 7 at the same edge → `regs[7]` = 0 and `written[7]` = 0.
- Sweep and saturation:
  - write every address 0–31 with data = index × 64'h0101 → each `regs[i]` = i × 64'h0101 for i < 31, `regs[31]` = 0;
  - then hold `wr_en` = 1 for 70 000 cycles → `wr_count` = 16'hFFFF.
